ch_start_sequencer: RTL and testbench

CH_START_SEQUENCER -- requirements
Module: ch_start_sequencer

---
 rtl/ch_start_sequencer_pkg.sv | 22 ++
 rtl/ch_start_sequencer_edge_det.sv | 27 ++
 rtl/ch_start_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_ch_start_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ch_start_sequencer_pkg.sv
// Shared definitions for ch_start_sequencer: FSM states, register map and reset values.
// The burst register at ADDR_BURST exists only when SEQ_BURST_EN is defined.
package ch_start_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHARGE  = 2'd1,
    ST_RUN     = 2'd2,
    ST_HOLDOFF = 2'd3
  } seq_state_t;

  localparam logic [1:0] ADDR_DELAY   = 2'd0;
  localparam logic [1:0] ADDR_WIDTH   = 2'd1;
  localparam logic [1:0] ADDR_HOLDOFF = 2'd2;
  localparam logic [1:0] ADDR_BURST   = 2'd3;

  localparam int RST_DELAY   = 0;
  localparam int RST_WIDTH   = 0;
  localparam int RST_HOLDOFF = 0;
  localparam int RST_BURST   = 1;

endpackage

// File: rtl/ch_start_sequencer_edge_det.sv
// Registered edge detector; the first clock after reset only captures history,
// so a level already high at reset release never reports an edge.
module seq_edge_det #(
  parameter bit FALL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_edge
);

  logic r_prev;
  logic r_armed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_sig;
      r_armed <= 1'b1;
    end
  end

  assign o_edge = r_armed & (FALL ? (~i_sig & r_prev) : (i_sig & ~r_prev));

endmodule

// File: rtl/ch_start_sequencer.sv
// Channel start sequencer: on a trigger edge runs CHARGE -> RUN -> HOLDOFF against a counter stage.
// Define SEQ_BURST_EN to add the burst-count register (addr 3) and the repeat loop.
//
// state      | meaning
// ST_IDLE    | waiting for trigger edge; rejects it when disabled or delay is 0
// ST_CHARGE  | first-charge strobe high for max(width,1) cycles
// ST_RUN     | counter started, waiting for i_ch_out or timeout
// ST_HOLDOFF | counter stopped for max(holdoff,1) cycles, then repeat or finish
module ch_start_sequencer #(
  parameter int DATA_W    = 16,
  parameter int CW_W      = 8,
  parameter int TO_MARGIN = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_trig,
  input  logic              i_ch_enable,
  input  logic              i_wr,
  input  logic [1:0]        i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_ch_out,
  output logic              o_first_charge,
  output logic              o_start,
  output logic [DATA_W-1:0] o_data,
  output logic              o_high_del,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  import ch_start_sequencer_pkg::*;

  localparam logic [DATA_W-1:0] ONE_D = DATA_W'(1);
  localparam logic [DATA_W:0]   ONE_T = (DATA_W+1)'(1);

  seq_state_t        r_state;
  logic [DATA_W-1:0] r_sh_delay;
  logic [CW_W-1:0]   r_sh_width;
  logic [DATA_W-1:0] r_sh_holdoff;
  logic [DATA_W-1:0] r_act_delay;
  logic [CW_W-1:0]   r_act_width;
  logic [DATA_W-1:0] r_act_holdoff;
  logic [DATA_W-1:0] r_cnt;
  logic [DATA_W:0]   r_tmo;
  logic              r_first_charge;
  logic              r_start;
  logic              r_busy;
  logic              r_high_del;
  logic              r_done;
  logic              r_err;

  logic              w_trig_rise;
  logic              w_en_fall;
  logic              w_accept;
  logic              w_abort;
  logic              w_more_burst;
  logic [DATA_W-1:0] w_sh_charge_len;
  logic [DATA_W-1:0] w_act_charge_len;
  logic [DATA_W-1:0] w_hold_len;
  logic [DATA_W:0]   w_tmo_load;

  seq_edge_det #(.FALL(1'b0)) u_trig_det (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_trig),
    .o_edge  (w_trig_rise)
  );

  seq_edge_det #(.FALL(1'b1)) u_en_det (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_ch_enable),
    .o_edge  (w_en_fall)
  );

  assign w_accept = (r_state == ST_IDLE) && w_trig_rise && i_ch_enable && (r_sh_delay != '0);
  assign w_abort  = (r_state != ST_IDLE) && w_en_fall;

  assign w_sh_charge_len  = (r_sh_width == '0)    ? ONE_D : DATA_W'(r_sh_width);
  assign w_act_charge_len = (r_act_width == '0)   ? ONE_D : DATA_W'(r_act_width);
  assign w_hold_len       = (r_act_holdoff == '0) ? ONE_D : r_act_holdoff;
  // One bit wider than the delay so a full-scale delay plus margin cannot wrap.
  assign w_tmo_load       = {1'b0, r_act_delay} + (DATA_W+1)'(TO_MARGIN);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh_delay   <= DATA_W'(RST_DELAY);
      r_sh_width   <= CW_W'(RST_WIDTH);
      r_sh_holdoff <= DATA_W'(RST_HOLDOFF);
    end else if (i_wr) begin
      case (i_wr_addr)
        ADDR_DELAY:   r_sh_delay   <= i_wr_data;
        ADDR_WIDTH:   r_sh_width   <= i_wr_data[CW_W-1:0];
        ADDR_HOLDOFF: r_sh_holdoff <= i_wr_data;
        default:      ;
      endcase
    end
  end

`ifdef SEQ_BURST_EN
  logic [DATA_W-1:0] r_sh_burst;
  logic [DATA_W-1:0] r_burst_rem;
  logic              w_loop;

  assign w_loop = (r_state == ST_HOLDOFF) && !w_abort && (r_cnt == ONE_D) && w_more_burst;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh_burst  <= DATA_W'(RST_BURST);
      r_burst_rem <= DATA_W'(RST_BURST);
    end else begin
      if (i_wr && (i_wr_addr == ADDR_BURST)) r_sh_burst <= i_wr_data;
      if (w_accept)    r_burst_rem <= (r_sh_burst == '0) ? ONE_D : r_sh_burst;
      else if (w_loop) r_burst_rem <= r_burst_rem - ONE_D;
    end
  end

  assign w_more_burst = (r_burst_rem > ONE_D);
`else
  assign w_more_burst = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_tmo          <= '0;
      r_act_delay    <= '0;
      r_act_width    <= '0;
      r_act_holdoff  <= '0;
      r_first_charge <= 1'b0;
      r_start        <= 1'b0;
      r_busy         <= 1'b0;
      r_high_del     <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_high_del <= 1'b0;
      if (w_abort) begin
        r_state        <= ST_IDLE;
        r_first_charge <= 1'b0;
        r_start        <= 1'b0;
        r_busy         <= 1'b0;
        r_high_del     <= 1'b1;
      end else begin
        if ((r_state != ST_IDLE) && w_trig_rise) r_err <= 1'b1;
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_act_delay    <= r_sh_delay;
              r_act_width    <= r_sh_width;
              r_act_holdoff  <= r_sh_holdoff;
              r_cnt          <= w_sh_charge_len;
              r_first_charge <= 1'b1;
              r_busy         <= 1'b1;
              r_state        <= ST_CHARGE;
            end else if (w_trig_rise) begin
              r_err <= 1'b1;
            end
          end
          ST_CHARGE: begin
            if (r_cnt == ONE_D) begin
              r_first_charge <= 1'b0;
              r_start        <= 1'b1;
              r_tmo          <= w_tmo_load;
              r_state        <= ST_RUN;
            end else begin
              r_cnt <= r_cnt - ONE_D;
            end
          end
          ST_RUN: begin
            if (i_ch_out) begin
              r_start <= 1'b0;
              r_cnt   <= w_hold_len;
              r_state <= ST_HOLDOFF;
            end else if (r_tmo == ONE_T) begin
              r_start    <= 1'b0;
              r_high_del <= 1'b1;
              r_err      <= 1'b1;
              r_cnt      <= w_hold_len;
              r_state    <= ST_HOLDOFF;
            end else begin
              r_tmo <= r_tmo - ONE_T;
            end
          end
          ST_HOLDOFF: begin
            if (r_cnt == ONE_D) begin
              if (w_more_burst) begin
                r_cnt          <= w_act_charge_len;
                r_first_charge <= 1'b1;
                r_state        <= ST_CHARGE;
              end else begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end
            end else begin
              r_cnt <= r_cnt - ONE_D;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_first_charge = r_first_charge;
  assign o_start        = r_start;
  assign o_data         = r_act_delay;
  assign o_high_del     = r_high_del;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;

endmodule

// File: tb/tb_ch_start_sequencer.sv
// Randomized self-checking bench for ch_start_sequencer against a phase-timeline reference model.
// Expected burst behaviour follows SEQ_BURST_EN as defined for the build.
module tb_ch_start_sequencer;
  import ch_start_sequencer_pkg::*;

  localparam int DATA_W    = 16;
  localparam int CW_W      = 8;
  localparam int TO_MARGIN = 4;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_trig = 1'b0;
  logic              i_ch_enable = 1'b1;
  logic              i_wr = 1'b0;
  logic [1:0]        i_wr_addr = 2'd0;
  logic [DATA_W-1:0] i_wr_data = '0;
  logic              i_ch_out = 1'b0;
  logic              o_first_charge;
  logic              o_start;
  logic [DATA_W-1:0] o_data;
  logic              o_high_del;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  int n_checks = 0;
  int n_pass   = 0;

  // expected {first_charge, start, busy, done, err, high_del} per sample, and RUN index (0 = not RUN)
  logic [5:0] exp_q[$];
  int         ridx_q[$];

  always #5 i_clk = ~i_clk;

  ch_start_sequencer #(.DATA_W(DATA_W), .CW_W(CW_W), .TO_MARGIN(TO_MARGIN)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_trig         (i_trig),
    .i_ch_enable    (i_ch_enable),
    .i_wr           (i_wr),
    .i_wr_addr      (i_wr_addr),
    .i_wr_data      (i_wr_data),
    .i_ch_out       (i_ch_out),
    .o_first_charge (o_first_charge),
    .o_start        (o_start),
    .o_data         (o_data),
    .o_high_del     (o_high_del),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [5:0] obs();
    return {o_first_charge, o_start, o_busy, o_done, o_err, o_high_del};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic wr_reg(input logic [1:0] a, input int d);
    i_wr = 1'b1; i_wr_addr = a; i_wr_data = DATA_W'(d);
    tick();
    i_wr = 1'b0;
  endtask

  task automatic cfg(input int d, input int w, input int h, input int b);
    wr_reg(ADDR_DELAY, d);
    wr_reg(ADDR_WIDTH, w);
    wr_reg(ADDR_HOLDOFF, h);
    wr_reg(ADDR_BURST, b);
  endtask

  // Timeline model: each burst pass is wl charge samples, nrun RUN samples, hl holdoff
  // samples; a timeout flags err/high_del on the first holdoff sample.
  task automatic build_exp(input int d, input int w, input int h, input int b, input int k);
    int wl, hl, lim, nrun, beff;
    bit tmo;
    wl  = (w == 0) ? 1 : w;
    hl  = (h == 0) ? 1 : h;
    lim = d + TO_MARGIN;
`ifdef SEQ_BURST_EN
    beff = (b == 0) ? 1 : b;
`else
    beff = 1;
`endif
    if (k >= 1 && k <= lim) begin nrun = k; tmo = 1'b0; end
    else begin nrun = lim; tmo = 1'b1; end
    exp_q.delete();
    ridx_q.delete();
    for (int it = 0; it < beff; it++) begin
      for (int j = 0; j < wl; j++) begin exp_q.push_back(6'b101000); ridx_q.push_back(0); end
      for (int r = 1; r <= nrun; r++) begin exp_q.push_back(6'b011000); ridx_q.push_back(r); end
      for (int j = 0; j < hl; j++) begin
        exp_q.push_back((j == 0 && tmo) ? 6'b001011 : 6'b001000);
        ridx_q.push_back(0);
      end
    end
    exp_q.push_back(6'b000100); ridx_q.push_back(0);
    exp_q.push_back(6'b000000); ridx_q.push_back(0);
  endtask

  task automatic run_seq(input string tag, input int d, input int w, input int h, input int b,
                         input int k, input int retrig_s, input int wr_val);
    build_exp(d, w, h, b, k);
    if (retrig_s > 0) exp_q[retrig_s] = exp_q[retrig_s] | 6'b000010;
    i_trig = 1'b1;
    for (int s = 1; s <= exp_q.size(); s++) begin
      tick();
      chk($sformatf("%s outs s%0d", tag, s), 32'(obs()), 32'(exp_q[s-1]));
      if (ridx_q[s-1] > 0) chk($sformatf("%s data s%0d", tag, s), 32'(o_data), d);
      i_trig    = (retrig_s > 0 && s == retrig_s);
      i_ch_out  = (k > 0 && ridx_q[s-1] == k);
      i_wr      = (wr_val > 0 && s == 2);
      i_wr_addr = ADDR_DELAY;
      i_wr_data = DATA_W'(wr_val);
    end
    i_trig = 1'b0; i_ch_out = 1'b0; i_wr = 1'b0;
  endtask

  task automatic trig_reject(input string tag);
    i_trig = 1'b1;
    tick();
    chk({tag, " err"}, 32'(obs()), 32'(6'b000010));
    i_trig = 1'b0;
    tick();
    chk({tag, " after"}, 32'(obs()), 32'(6'b000000));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, w, h, b, k, rs;
    repeat (3) tick();
    chk("reset outs", 32'(obs()), 32'(6'b000000));
    chk("reset data", 32'(o_data), 0);
    i_rst_n = 1'b1;
    repeat (2) tick();

    trig_reject("delay0 default");
    cfg(0, 2, 2, 1);
    trig_reject("delay0");
    wr_reg(ADDR_DELAY, 5);
    i_ch_enable = 1'b0;
    tick();
    trig_reject("disabled");
    i_ch_enable = 1'b1;
    tick();

    cfg(10, 3, 5, 1);
    run_seq("basic", 10, 3, 5, 1, 10, 0, 0);
    run_seq("timeout", 10, 3, 5, 1, 0, 0, 0);
    cfg(10, 1, 1, 1);
    run_seq("tie", 10, 1, 1, 1, 14, 0, 0);
    cfg(6, 2, 3, 3);
    run_seq("burst3", 6, 2, 3, 3, 4, 0, 0);
    cfg(10, 2, 2, 1);
    run_seq("shadow wr", 10, 2, 2, 1, 5, 4, 20);
    run_seq("shadow new", 20, 2, 2, 1, 7, 0, 0);

    for (int it = 0; it < 10; it++) begin
      d  = $urandom_range(1, 12);
      w  = $urandom_range(0, 4);
      h  = $urandom_range(0, 4);
      b  = $urandom_range(0, 3);
      k  = $urandom_range(0, d + TO_MARGIN + 2);
      rs = ($urandom_range(0, 1) == 1) ? ((w == 0) ? 1 : w) + 1 : 0;
      cfg(d, w, h, b);
      run_seq($sformatf("rnd%0d", it), d, w, h, b, k, rs, 0);
    end

    cfg(8, 4, 2, 1);
    i_trig = 1'b1;
    tick();
    chk("abort charge", 32'(obs()), 32'(6'b101000));
    i_trig = 1'b0;
    i_ch_enable = 1'b0;
    tick();
    chk("abort pulse", 32'(obs()), 32'(6'b000001));
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("abort idle", 32'(obs()), 32'(6'b000000));
    end
    i_ch_enable = 1'b1;
    tick();

    cfg(8, 1, 2, 1);
    i_trig = 1'b1;
    tick();
    tick();
    chk("pre-reset run", 32'(obs()), 32'(6'b011000));
    #2 i_rst_n = 1'b0;
    #1 chk("async reset outs", 32'(obs()), 32'(6'b000000));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("trig high at release", 32'(obs()), 32'(6'b000000));
    end
    i_trig = 1'b0;
    tick();
    trig_reject("shadow reset");
    cfg(3, 1, 1, 1);
    run_seq("post reset", 3, 1, 1, 1, 2, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
